// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: memory-wait FSM with timeout,
// mult/div latency counter, and all PC/pipeline-register control. Optional macro: STALL_COUNTER_EN.
module pipeline_ctrl #(
  parameter int MD_CYCLES   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MemRd_ID_EX,
  input  logic [4:0] RegisterRt_ID_EX,
  input  logic [4:0] RegisterRs_IF_ID,
  input  logic [4:0] RegisterRt_IF_ID,
  input  logic       BranchTaken_EX,
  input  logic       MemReq_MEM,
  input  logic       MemReady,
  input  logic       MdStart_EX,
  input  logic       MdUse_ID,
  output logic       PCWr,
  output logic       IF_ID_Wr,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Wr,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Wr,
  output logic       MEM_WB_Wr,
  output logic       MdBusy,
  output logic       MemErr
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0] StallCycles
`endif
);

  localparam int CNT_W  = $clog2(MD_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  MD_LOAD   = CNT_W'(MD_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t            state;
  state_t            stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  mdCnt;
  logic              memWaitStart;
  logic              freeze;
  logic              timeout;
  logic              loadUse;
  logic              mdUseStall;
  logic              mdBusyInt;

  assign memWaitStart = (state == RUN) && MemReq_MEM && !MemReady;
  assign freeze       = memWaitStart || ((state == MEM_WAIT) && !MemReady);
  // waitCnt holds the MEM_WAIT cycles already elapsed, so the current cycle is number waitCnt+1.
  assign timeout      = (state == MEM_WAIT) && !MemReady && (waitCnt == WAIT_LAST);

  assign loadUse    = MemRd_ID_EX && (RegisterRt_ID_EX != 5'd0) &&
                      ((RegisterRt_ID_EX == RegisterRs_IF_ID) ||
                       (RegisterRt_ID_EX == RegisterRt_IF_ID));
  assign mdBusyInt  = (mdCnt != '0);
  assign mdUseStall = MdUse_ID && mdBusyInt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (memWaitStart) stateNext = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (MemReady || timeout) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    PCWr        = 1'b1;
    IF_ID_Wr    = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Wr    = 1'b1;
    ID_EX_Flush = 1'b0;
    EX_MEM_Wr   = 1'b1;
    MEM_WB_Wr   = 1'b1;
    MdBusy      = mdBusyInt;
    MemErr      = timeout;
    if (reset) begin
      PCWr      = 1'b0;
      IF_ID_Wr  = 1'b0;
      ID_EX_Wr  = 1'b0;
      EX_MEM_Wr = 1'b0;
      MEM_WB_Wr = 1'b0;
      MdBusy    = 1'b0;
      MemErr    = 1'b0;
    end else if (freeze) begin
      PCWr      = 1'b0;
      IF_ID_Wr  = 1'b0;
      ID_EX_Wr  = 1'b0;
      EX_MEM_Wr = 1'b0;
      MEM_WB_Wr = 1'b0;
    end else if (BranchTaken_EX) begin
      // The ID instruction is squashed, so any hazard it carries is irrelevant.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (loadUse || mdUseStall) begin
      PCWr        = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
    end else if ((state == MEM_WAIT) && !MemReady && !timeout) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end else begin
      waitCnt <= '0;
    end
  end

  // A frozen EX stage cannot issue, so the load is qualified by EX_MEM_Wr; the newest op always reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdCnt <= '0;
    end else if (MdStart_EX && EX_MEM_Wr) begin
      mdCnt <= MD_LOAD;
    end else if (mdBusyInt) begin
      mdCnt <= mdCnt - CNT_W'(1);
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= '0;
    end else if (!PCWr) begin
      StallCycles <= StallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MD_CYCLES=3, MEM_TIMEOUT=4) with an expected-value queue.
module tb_pipeline_ctrl;

  // Packed output order: PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, MEM_WB_Wr, MdBusy, MemErr
  localparam logic [8:0] ZERO  = 9'b000000000;
  localparam logic [8:0] NORM  = 9'b110101100;
  localparam logic [8:0] NORMB = 9'b110101110;
  localparam logic [8:0] BR    = 9'b111111100;
  localparam logic [8:0] STL   = 9'b000111100;
  localparam logic [8:0] STLB  = 9'b000111110;
  localparam logic [8:0] FRZB  = 9'b000000010;
  localparam logic [8:0] FRZE  = 9'b000000001;

  logic       clk;
  logic       reset;
  logic       MemRd_ID_EX;
  logic [4:0] RegisterRt_ID_EX;
  logic [4:0] RegisterRs_IF_ID;
  logic [4:0] RegisterRt_IF_ID;
  logic       BranchTaken_EX;
  logic       MemReq_MEM;
  logic       MemReady;
  logic       MdStart_EX;
  logic       MdUse_ID;
  logic       PCWr;
  logic       IF_ID_Wr;
  logic       IF_ID_Flush;
  logic       ID_EX_Wr;
  logic       ID_EX_Flush;
  logic       EX_MEM_Wr;
  logic       MEM_WB_Wr;
  logic       MdBusy;
  logic       MemErr;
`ifdef STALL_COUNTER_EN
  logic [31:0] StallCycles;
`endif

  logic [8:0] sbq[$];
  int vectors = 0;
  int miscompares = 0;

  pipeline_ctrl #(.MD_CYCLES(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .MemRd_ID_EX(MemRd_ID_EX),
    .RegisterRt_ID_EX(RegisterRt_ID_EX),
    .RegisterRs_IF_ID(RegisterRs_IF_ID),
    .RegisterRt_IF_ID(RegisterRt_IF_ID),
    .BranchTaken_EX(BranchTaken_EX),
    .MemReq_MEM(MemReq_MEM),
    .MemReady(MemReady),
    .MdStart_EX(MdStart_EX),
    .MdUse_ID(MdUse_ID),
    .PCWr(PCWr),
    .IF_ID_Wr(IF_ID_Wr),
    .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Wr(ID_EX_Wr),
    .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Wr(EX_MEM_Wr),
    .MEM_WB_Wr(MEM_WB_Wr),
    .MdBusy(MdBusy),
    .MemErr(MemErr)
`ifdef STALL_COUNTER_EN
    ,
    .StallCycles(StallCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    MemRd_ID_EX      = 1'b0;
    RegisterRt_ID_EX = 5'd0;
    RegisterRs_IF_ID = 5'd0;
    RegisterRt_IF_ID = 5'd0;
    BranchTaken_EX   = 1'b0;
    MemReq_MEM       = 1'b0;
    MemReady         = 1'b0;
    MdStart_EX       = 1'b0;
    MdUse_ID         = 1'b0;
  endtask

  task automatic compare(input string tag);
    logic [8:0] obs;
    logic [8:0] exp;
    exp = sbq.pop_front();
    obs = {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, MEM_WB_Wr, MdBusy, MemErr};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  // Inputs are already driven for this cycle; sample on the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [8:0] exp);
    sbq.push_back(exp);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    MemRd_ID_EX = 1'b1; RegisterRt_ID_EX = 5'd5; RegisterRs_IF_ID = 5'd5;
    step("reset_state", ZERO);
    reset = 1'b0;
    clear_inputs();
    step("idle", NORM);

    // Load-use hazards
    MemRd_ID_EX = 1'b1; RegisterRt_ID_EX = 5'd5; RegisterRs_IF_ID = 5'd5;
    step("loaduse_rs", STL);
    clear_inputs();
    step("loaduse_release", NORM);
    MemRd_ID_EX = 1'b1; RegisterRt_ID_EX = 5'd0; RegisterRs_IF_ID = 5'd0;
    step("loaduse_r0", NORM);
    RegisterRt_ID_EX = 5'd7; RegisterRs_IF_ID = 5'd6; RegisterRt_IF_ID = 5'd7;
    step("loaduse_rt", STL);
    RegisterRt_IF_ID = 5'd8;
    step("loaduse_nomatch", NORM);
    MemRd_ID_EX = 1'b0; RegisterRs_IF_ID = 5'd7;
    step("loaduse_noload", NORM);

    // Branch beats load-use
    MemRd_ID_EX = 1'b1; RegisterRt_ID_EX = 5'd5; RegisterRs_IF_ID = 5'd5; BranchTaken_EX = 1'b1;
    step("branch_over_loaduse", BR);
    clear_inputs();

    // Memory wait: three frozen cycles then release
    MemReq_MEM = 1'b1; MemReady = 1'b0;
    step("memwait_c1", ZERO);
    BranchTaken_EX = 1'b1; MemRd_ID_EX = 1'b1; RegisterRt_ID_EX = 5'd5; RegisterRs_IF_ID = 5'd5;
    step("memwait_c2_masks", ZERO);
    clear_inputs(); MemReq_MEM = 1'b1;
    step("memwait_c3", ZERO);
    MemReady = 1'b1;
    step("memwait_ready", NORM);
    clear_inputs();
    step("memwait_back_run", NORM);
    MemReq_MEM = 1'b1; MemReady = 1'b1;
    step("req_and_ready", NORM);
    clear_inputs();
    step("after_req_ready", NORM);

    // Timeout: MemErr on the 4th MEM_WAIT cycle, then RUN
    MemReq_MEM = 1'b1; MemReady = 1'b0;
    step("timeout_enter", ZERO);
    step("timeout_w1", ZERO);
    step("timeout_w2", ZERO);
    step("timeout_w3", ZERO);
    step("timeout_err", FRZE);
    MemReq_MEM = 1'b0;
    step("timeout_run", NORM);

    // Mult/div latency with HI/LO use stall
    MdUse_ID = 1'b1; MdStart_EX = 1'b1;
    step("md_issue", NORM);
    MdStart_EX = 1'b0;
    step("md_t1", STLB);
    step("md_t2", STLB);
    step("md_t3", STLB);
    step("md_t4_release", NORM);
    MdUse_ID = 1'b0;

    // Reissue while busy reloads the counter
    MdStart_EX = 1'b1;
    step("md_reload_t0", NORM);
    step("md_reload_t1", NORMB);
    MdStart_EX = 1'b0;
    step("md_reload_t2", NORMB);
    step("md_reload_t3", NORMB);
    step("md_reload_t4", NORMB);
    step("md_reload_t5", NORM);

    // Issue during freeze is ignored
    MemReq_MEM = 1'b1; MdStart_EX = 1'b1;
    step("md_frozen_issue", ZERO);
    MemReady = 1'b1; MemReq_MEM = 1'b0; MdStart_EX = 1'b0;
    step("md_frozen_noload", NORM);
    clear_inputs();

    // Counter keeps decrementing while frozen
    MdStart_EX = 1'b1;
    step("md_dec_issue", NORM);
    MdStart_EX = 1'b0; MemReq_MEM = 1'b1;
    step("md_dec_frozen", FRZB);
    MemReady = 1'b1;
    step("md_dec_after", NORMB);
    clear_inputs();
    step("md_dec_last", NORMB);
    step("md_dec_done", NORM);

    // Asynchronous reset in the middle of a memory wait
    MdStart_EX = 1'b1;
    step("ar_issue", NORM);
    MdStart_EX = 1'b0; MemReq_MEM = 1'b1; MemReady = 1'b0;
    step("ar_enter_wait", FRZB);
    step("ar_in_wait", FRZB);
    #2;
    reset = 1'b1;
    #1;
    sbq.push_back(ZERO);
    compare("async_reset_immediate");
    MemRd_ID_EX = 1'b1; RegisterRt_ID_EX = 5'd5; RegisterRs_IF_ID = 5'd5;
    step("reset_hold", ZERO);
    reset = 1'b0;
    clear_inputs();
    MdUse_ID = 1'b1;
    step("after_reset_run", NORM);
    MdUse_ID = 1'b0;
    step("after_reset_idle", NORM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
